// File: rtl/csr_spmv_lanes.sv
// CSR sparse-matrix x LANES dense-vector engine: walks row pointers, streams one nnz per
// cycle shared by all lanes, and hands out one accumulated result per row over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start
// PTR0   | first row pointer on rp_data, becomes base
// PTRN   | next row pointer on rp_data, becomes end of current row
// STREAM | issuing nz_addr = base .. end-1, one per cycle
// DRAIN  | last products still travelling to the accumulators
// EMIT   | result presented, held until res_ready
// FIN    | one-cycle done pulse
module csr_spmv_lanes #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int NNZ_AW = 14,
    parameter int ROW_AW = 10,
    parameter int COL_AW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_AW-1:0]        num_rows,
    output logic [ROW_AW-1:0]        rp_addr,
    input  logic [NNZ_AW-1:0]        rp_data,
    output logic [NNZ_AW-1:0]        nz_addr,
    input  logic [DATA_W-1:0]        nz_val,
    input  logic [COL_AW-1:0]        nz_col,
    output logic [COL_AW-1:0]        vec_addr,
    input  logic [LANES*DATA_W-1:0]  vec_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROW_AW-1:0]        res_row,
    output logic [LANES*ACC_W-1:0]   res_data,
    output logic                     res_zero,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PTR0, S_PTRN, S_STREAM, S_DRAIN, S_EMIT, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [ROW_AW-1:0] rows_q;
    logic [ROW_AW-1:0] row_q;
    logic [NNZ_AW-1:0] base_q;
    logic [NNZ_AW-1:0] end_q;
    logic [1:0]        drain_cnt;
    logic              zero_q;
    logic              err_q;

    logic                     v1, v2, v3;
    logic signed [DATA_W-1:0] val_q;
    logic signed [DATA_W-1:0] lane_x [LANES];
    logic signed [2*DATA_W-1:0] prod [LANES];
    logic [ACC_W-1:0]         acc [LANES];

    logic ptr_fwd, ptr_back, last_issue, last_row;

    assign ptr_fwd    = rp_data > base_q;
    assign ptr_back   = rp_data < base_q;
    assign last_issue = nz_addr == (end_q - NNZ_AW'(1));
    assign last_row   = (row_q + ROW_AW'(1)) == rows_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = (num_rows == '0) ? S_FIN : S_PTR0;
            S_PTR0:   state_nxt = S_PTRN;
            S_PTRN:   state_nxt = ptr_fwd ? S_STREAM : S_EMIT;
            S_STREAM: if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt == 2'd0) state_nxt = S_EMIT;
            S_EMIT:   if (res_ready) state_nxt = last_row ? S_FIN : S_PTRN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE) && (state != S_FIN);
        done      = state == S_FIN;
        res_valid = state == S_EMIT;
    end

    // A malformed (decreasing) pointer is treated as an empty row; its end still becomes the next base.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q    <= '0;
            row_q     <= '0;
            base_q    <= '0;
            end_q     <= '0;
            rp_addr   <= '0;
            nz_addr   <= '0;
            drain_cnt <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rows_q  <= num_rows;
                    row_q   <= '0;
                    rp_addr <= '0;
                    err_q   <= 1'b0;
                end
                S_PTR0: begin
                    base_q  <= rp_data;
                    rp_addr <= row_q + ROW_AW'(1);
                end
                S_PTRN: begin
                    end_q  <= rp_data;
                    zero_q <= !ptr_fwd;
                    if (ptr_back) err_q <= 1'b1;
                    if (ptr_fwd) nz_addr <= base_q;
                end
                S_STREAM: begin
                    if (last_issue) drain_cnt <= 2'd2;
                    else            nz_addr   <= nz_addr + NNZ_AW'(1);
                end
                S_DRAIN: if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
                S_EMIT: if (res_ready) begin
                    row_q  <= row_q + ROW_AW'(1);
                    base_q <= end_q;
                    if (!last_row) rp_addr <= row_q + ROW_AW'(2);
                end
                default: ;
            endcase
        end
    end

    // Pipeline: value/column (v1), vector element (v2), product (v3), then accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            val_q <= '0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            v1 <= state == S_STREAM;
            v2 <= v1;
            v3 <= v2;
            if (v1) val_q <= nz_val;
            if (v2) begin
                for (int i = 0; i < LANES; i++) prod[i] <= val_q * lane_x[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (state == S_PTRN) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (v3) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc[i] + ACC_W'(prod[i]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_x[g]                 = vec_data[g*DATA_W +: DATA_W];
            assign res_data[g*ACC_W +: ACC_W] = acc[g];
        end
    endgenerate

    assign vec_addr = nz_col;
    assign res_row  = row_q;
    assign res_zero = zero_q;
    assign err      = err_q;

endmodule

// File: tb/tb_csr_spmv_lanes.sv
// Bench for csr_spmv_lanes: directed table jobs, multi-cycle corner sequences and
// random jobs checked against a row-by-row arithmetic model of the CSR product.
module tb_csr_spmv_lanes;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   num_rows;
    logic [9:0]   rp_addr;
    logic [13:0]  rp_data;
    logic [13:0]  nz_addr;
    logic [31:0]  nz_val;
    logic [9:0]   nz_col;
    logic [9:0]   vec_addr;
    logic [63:0]  vec_data;
    logic         res_valid;
    logic         res_ready;
    logic [9:0]   res_row;
    logic [127:0] res_data;
    logic         res_zero;
    logic         busy;
    logic         done;
    logic         err;

    csr_spmv_lanes dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .rp_addr(rp_addr), .rp_data(rp_data), .nz_addr(nz_addr),
        .nz_val(nz_val), .nz_col(nz_col), .vec_addr(vec_addr), .vec_data(vec_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_data(res_data), .res_zero(res_zero), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [13:0] rp_mem  [0:1023];
    logic [31:0] val_mem [0:16383];
    logic [9:0]  col_mem [0:16383];
    logic [31:0] vec_mem0 [0:1023];
    logic [31:0] vec_mem1 [0:1023];

    // Row pointers are read through the registered rp_addr; the others are synchronous RAMs.
    assign rp_data = rp_mem[rp_addr];
    always @(posedge clk) begin
        nz_val   <= val_mem[nz_addr];
        nz_col   <= col_mem[nz_addr];
        vec_data <= {vec_mem1[vec_addr], vec_mem0[vec_addr]};
    end

    typedef struct {
        logic [9:0]  row;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        z;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int     nrows;
        int     rp[5];
        int     val[8];
        int     col[8];
        longint e0[3];
        longint e1[3];
        bit     ez[3];
        bit     eerr;
        bit     min_x;
    } vec_rec_t;
    vec_rec_t tbl[4];

    int n_tests = 0;
    int n_fail  = 0;
    int ready_pct = 100;
    bit manual_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Result monitor: every presented result is compared with the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got row %0d expected no result", res_row);
            end else begin
                check("res_row", 64'(res_row), 64'(exp_q[0].row));
                check("res_zero", 64'(res_zero), 64'(exp_q[0].z));
                check("res_lane0", res_data[63:0], exp_q[0].d0);
                check("res_lane1", res_data[127:64], exp_q[0].d1);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual_ready) res_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic clear_mem();
        for (int k = 0; k < 64; k++) begin
            val_mem[k] = '0;
            col_mem[k] = '0;
        end
        for (int k = 0; k < 16; k++) rp_mem[k] = '0;
    endtask

    task automatic load_tbl(input int i);
        clear_mem();
        for (int k = 0; k < 5; k++) rp_mem[k] = 14'(tbl[i].rp[k]);
        for (int k = 0; k < 8; k++) begin
            val_mem[k] = 32'(tbl[i].val[k]);
            col_mem[k] = 10'(tbl[i].col[k]);
        end
        for (int c = 0; c < 1024; c++) begin
            vec_mem0[c] = tbl[i].min_x ? 32'h8000_0000 : 32'(c + 1);
            vec_mem1[c] = tbl[i].min_x ? 32'h8000_0000 : 32'(10 * (c + 1));
        end
        for (int r = 0; r < tbl[i].nrows; r++) begin
            exp_t x;
            x.row = 10'(r);
            x.d0  = 64'(tbl[i].e0[r]);
            x.d1  = 64'(tbl[i].e1[r]);
            x.z   = tbl[i].ez[r];
            exp_q.push_back(x);
        end
    endtask

    task automatic start_job(input int nrows);
        @(posedge clk);
        #1;
        start    = 1'b1;
        num_rows = 10'(nrows);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_job(input bit exp_err);
        bit seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("busy_at_done", 64'(busy), 64'd0);
            check("pending_results", 64'(exp_q.size()), 64'd0);
            check("err_flag", 64'(err), 64'(exp_err));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end
        exp_q.delete();
    endtask

    task automatic gen_random(output int nrows);
        int p;
        clear_mem();
        nrows = int'($urandom_range(1, 5));
        for (int k = 0; k < 64; k++) begin
            val_mem[k] = $urandom;
            col_mem[k] = 10'($urandom_range(0, 1023));
        end
        for (int c = 0; c < 1024; c++) begin
            vec_mem0[c] = $urandom;
            vec_mem1[c] = $urandom;
        end
        p = int'($urandom_range(0, 8));
        rp_mem[0] = 14'(p);
        for (int r = 1; r <= nrows; r++) begin
            if (p > 1 && $urandom_range(0, 7) == 0) p = p - int'($urandom_range(1, 2));
            else                                   p = p + int'($urandom_range(0, 4));
            rp_mem[r] = 14'(p);
        end
    endtask

    // Reference: each row sums val*x[col] over [base, end), the row's end becoming the next base.
    task automatic model_push(input int nrows, output bit e_err);
        int b, e;
        exp_t x;
        logic [63:0] s0, s1;
        e_err = 1'b0;
        b = int'(rp_mem[0]);
        for (int r = 0; r < nrows; r++) begin
            e  = int'(rp_mem[r + 1]);
            s0 = '0;
            s1 = '0;
            for (int k = b; k < e; k++) begin
                s0 = s0 + 64'(longint'($signed(val_mem[k])) * longint'($signed(vec_mem0[col_mem[k]])));
                s1 = s1 + 64'(longint'($signed(val_mem[k])) * longint'($signed(vec_mem1[col_mem[k]])));
            end
            if (e < b) e_err = 1'b1;
            x.row = 10'(r);
            x.d0  = s0;
            x.d1  = s1;
            x.z   = (e <= b);
            exp_q.push_back(x);
            b = e;
        end
    endtask

    initial begin
        int nr, lat;
        bit e_err, got_valid;
        int done_cnt;

        tbl[0].nrows = 3; tbl[0].rp = '{0, 2, 2, 3, 0};
        tbl[0].val = '{3, -2, 5, 0, 0, 0, 0, 0}; tbl[0].col = '{0, 4, 1, 0, 0, 0, 0, 0};
        tbl[0].e0 = '{-7, 0, 10}; tbl[0].e1 = '{-70, 0, 100}; tbl[0].ez = '{0, 1, 0};
        tbl[0].eerr = 0; tbl[0].min_x = 0;

        tbl[1].nrows = 3; tbl[1].rp = '{0, 3, 1, 4, 0};
        tbl[1].val = '{1, 2, 3, 4, 0, 0, 0, 0}; tbl[1].col = '{0, 1, 2, 3, 0, 0, 0, 0};
        tbl[1].e0 = '{14, 0, 29}; tbl[1].e1 = '{140, 0, 290}; tbl[1].ez = '{0, 1, 0};
        tbl[1].eerr = 1; tbl[1].min_x = 0;

        tbl[2].nrows = 1; tbl[2].rp = '{0, 4, 0, 0, 0};
        tbl[2].val = '{int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), 0, 0, 0, 0};
        tbl[2].col = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].e0 = '{0, 0, 0}; tbl[2].e1 = '{0, 0, 0}; tbl[2].ez = '{0, 0, 0};
        tbl[2].eerr = 0; tbl[2].min_x = 1;

        tbl[3].nrows = 1; tbl[3].rp = '{0, 1, 0, 0, 0};
        tbl[3].val = '{-1, 0, 0, 0, 0, 0, 0, 0}; tbl[3].col = '{7, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].e0 = '{-8, 0, 0}; tbl[3].e1 = '{-80, 0, 0}; tbl[3].ez = '{0, 0, 0};
        tbl[3].eerr = 0; tbl[3].min_x = 0;

        for (int k = 0; k < 1024; k++) begin
            rp_mem[k] = '0; vec_mem0[k] = '0; vec_mem1[k] = '0;
        end
        for (int k = 0; k < 16384; k++) begin
            val_mem[k] = '0; col_mem[k] = '0;
        end

        rst = 1'b0; start = 1'b0; num_rows = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({busy, done, res_valid, res_zero, err}), 64'd0);
        check("reset_rp_addr", 64'(rp_addr), 64'd0);
        check("reset_nz_addr", 64'(nz_addr), 64'd0);
        check("reset_res_data", res_data[63:0] | res_data[127:64], 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ready_pct = (i == 0) ? 100 : 50;
            load_tbl(i);
            start_job(tbl[i].nrows);
            finish_job(tbl[i].eerr);
        end

        // Backpressure on row 0 with a stray start while stalled.
        ready_pct = 100;
        manual_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        load_tbl(0);
        start_job(3);
        lat = 0;
        got_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        check("first_result_seen", 64'(got_valid), 64'd1);
        check("first_result_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_rp_addr", 64'(rp_addr), 64'd1);
            check("stall_nz_addr", 64'(nz_addr), 64'd1);
            if (i == 1) begin
                start = 1'b1;
                num_rows = '0;
            end
            if (i == 2) start = 1'b0;
        end
        res_ready = 1'b1;
        manual_ready = 1'b0;
        finish_job(1'b0);

        // Empty job.
        start_job(0);
        @(negedge clk);
        check("empty_done", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("empty_after", 64'({done, busy, res_valid}), 64'd0);

        // Reset in the middle of STREAM.
        load_tbl(0);
        exp_q.delete();
        start_job(3);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_ctrl", 64'({busy, done, res_valid, res_zero, err}), 64'd0);
        check("midrst_addrs", 64'({rp_addr, nz_addr, res_row}), 64'd0);
        check("midrst_res_data", res_data[63:0] | res_data[127:64], 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        load_tbl(0);
        start_job(3);
        finish_job(1'b0);

        // Random jobs against the model.
        for (int j = 0; j < 20; j++) begin
            ready_pct = int'($urandom_range(30, 100));
            gen_random(nr);
            model_push(nr, e_err);
            start_job(nr);
            finish_job(e_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
